zigzag_inverso: RTL and testbench

- Inverse-scan stage directly upstream of the reescalador (coefficient rescaler).
- Accepts 4x4 residual coefficients one per cycle in zig-zag (scan) order from the entropy decoder.
- Reorders them into raster order through a ping-pong buffer and streams them to the reescalador, one per cycle.
- Each output coefficient carries its raster position and the block's QP.

---
 rtl/zigzag_pkg.sv | 30 +++
 rtl/zigzag_bank.sv | 32 +++
 rtl/zigzag_inverso.sv | 155 +++++++++++++++
 tb/tb_zigzag_inverso.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/zigzag_pkg.sv
// zigzag_pkg: shared types, width defaults and scan tables for the inverse zig-zag stage.
// The field scan table is only used by designs built with ZIGZAG_FIELD_SCAN_EN.
package zigzag_pkg;

  localparam int COEF_W_DEFAULT = 16;
  localparam int QP_W_DEFAULT   = 6;

  typedef logic signed [COEF_W_DEFAULT-1:0] coef_t;
  typedef logic [3:0]                       pos_t;

  // Raster position (row*4+col) of the coefficient arriving at each scan index.
  localparam pos_t SCAN_FRAME [16] = '{
    4'd0, 4'd1, 4'd4,  4'd8,  4'd5,  4'd2,  4'd3,  4'd6,
    4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
  };

  localparam pos_t SCAN_FIELD [16] = '{
    4'd0, 4'd4, 4'd1,  4'd8,  4'd12, 4'd5,  4'd9,  4'd13,
    4'd2, 4'd6, 4'd10, 4'd14, 4'd3,  4'd7,  4'd11, 4'd15
  };

  // Raster destination of scan index idx for the selected scan pattern.
  function automatic pos_t scan_pos(input logic field, input pos_t idx);
    pos_t p;
    if (field) p = SCAN_FIELD[idx];
    else       p = SCAN_FRAME[idx];
    return p;
  endfunction

endpackage

// File: rtl/zigzag_bank.sv
// zigzag_bank: one 16-entry coefficient bank, written at a raster position and
// read combinationally at a raster index. Contents are not reset.
module zigzag_bank
  import zigzag_pkg::*;
#(
  parameter int W = COEF_W_DEFAULT
) (
  input  logic         clk,
  input  logic         we,
  input  pos_t         wr_pos,
  input  logic [W-1:0] wr_data,
  input  pos_t         rd_idx,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] mem [16];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_entry
      // Each entry captures the incoming coefficient when addressed.
      always_ff @(posedge clk) begin
        if (we && (wr_pos == pos_t'(gi))) begin
          mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/zigzag_inverso.sv
// zigzag_inverso: reorders 4x4 blocks from scan order into raster order through a
// two-bank ping-pong buffer and streams them out with position and QP.
// Optional build macro: ZIGZAG_FIELD_SCAN_EN adds field_mode and the field scan.
module zigzag_inverso
  import zigzag_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEFAULT,
  parameter int QP_W   = QP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  input  logic [QP_W-1:0]   in_qp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_coef,
  output logic [3:0]        out_pos,
  output logic [QP_W-1:0]   out_qp,
  output logic              out_last
`ifdef ZIGZAG_FIELD_SCAN_EN
  ,
  input  logic              field_mode
`endif
);

  logic [1:0]        full;
  logic              wr_bank;
  logic              rd_bank;
  pos_t              wr_idx;
  pos_t              rd_idx;
  logic [QP_W-1:0]   qp_reg [2];
  logic [COEF_W-1:0] rd_data [2];

  logic wr_fire;
  logic rd_fire;
  logic wr_done;
  logic rd_done;
  logic field_cur;
  pos_t wr_pos;

  // Handshakes; flush cancels any transfer offered in the same cycle.
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign wr_fire   = in_valid && in_ready && !flush;
  assign rd_fire   = out_valid && out_ready && !flush;
  assign wr_done   = wr_fire && (wr_idx == 4'd15);
  assign rd_done   = rd_fire && (rd_idx == 4'd15);

`ifdef ZIGZAG_FIELD_SCAN_EN
  logic [1:0] field_reg;

  // The first coefficient of a block uses field_mode directly; later ones use the stored copy.
  assign field_cur = (wr_idx == 4'd0) ? field_mode : field_reg[wr_bank];

  // Scan selection is captured per bank together with the first coefficient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_reg <= '0;
    end else if (wr_fire && (wr_idx == 4'd0)) begin
      field_reg[wr_bank] <= field_mode;
    end
  end
`else
  assign field_cur = 1'b0;
`endif

  assign wr_pos = scan_pos(field_cur, wr_idx);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic bank_we;
      assign bank_we = wr_fire && (wr_bank == 1'(gi));

      zigzag_bank #(
        .W(COEF_W)
      ) u_bank (
        .clk     (clk),
        .we      (bank_we),
        .wr_pos  (wr_pos),
        .wr_data (in_coef),
        .rd_idx  (rd_idx),
        .rd_data (rd_data[gi])
      );
    end
  endgenerate

  // QP is latched per bank with scan index 0 and held until that bank is rewritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qp_reg <= '{default: '0};
    end else if (wr_fire && (wr_idx == 4'd0)) begin
      qp_reg[wr_bank] <= in_qp;
    end
  end

  // Full flags: the write side fills one bank while the read side empties the other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else if (flush) begin
      full <= '0;
    end else begin
      if (wr_done) full[wr_bank] <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  // Write pointer: walks the scan index and swaps banks after the 16th coefficient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (flush) begin
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (wr_fire) begin
      if (wr_idx == 4'd15) begin
        wr_bank <= !wr_bank;
        wr_idx  <= '0;
      end else begin
        wr_idx <= wr_idx + 4'd1;
      end
    end
  end

  // Read pointer: walks raster order and swaps banks after position 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
      rd_idx  <= '0;
    end else if (flush) begin
      rd_bank <= 1'b0;
      rd_idx  <= '0;
    end else if (rd_fire) begin
      if (rd_idx == 4'd15) begin
        rd_bank <= !rd_bank;
        rd_idx  <= '0;
      end else begin
        rd_idx <= rd_idx + 4'd1;
      end
    end
  end

  // Outputs come straight from state, so they hold while the consumer stalls.
  // The coefficient is zeroed when idle since the banks themselves are never reset.
  assign out_coef = out_valid ? rd_data[rd_bank] : '0;
  assign out_pos  = rd_idx;
  assign out_qp   = qp_reg[rd_bank];
  assign out_last = (rd_idx == 4'd15);

endmodule

// File: tb/tb_zigzag_inverso.sv
// tb_zigzag_inverso: randomized bench against a block-level reference model.
module tb_zigzag_inverso;

  localparam int CW = 16;
  localparam int QW = 6;
`ifdef ZIGZAG_FIELD_SCAN_EN
  localparam bit FIELD_EN = 1'b1;
`else
  localparam bit FIELD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_coef = '0;
  logic [QW-1:0] in_qp = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_coef;
  logic [3:0]    out_pos;
  logic [QW-1:0] out_qp;
  logic          out_last;
`ifdef ZIGZAG_FIELD_SCAN_EN
  logic          field_mode = 1'b0;
`endif

  always #5 clk = ~clk;

  zigzag_inverso #(.COEF_W(CW), .QP_W(QW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_coef   (in_coef),
    .in_qp     (in_qp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_coef  (out_coef),
    .out_pos   (out_pos),
    .out_qp    (out_qp),
    .out_last  (out_last)
`ifdef ZIGZAG_FIELD_SCAN_EN
    ,
    .field_mode(field_mode)
`endif
  );

  // Reference model: blocks are gathered in scan order, then unscanned as a whole.
  typedef struct {
    logic [CW-1:0] coef;
    logic [3:0]    pos;
    logic [QW-1:0] qp;
  } exp_t;

  exp_t          exp_q[$];
  logic [CW-1:0] out_log[$];
  logic [QW-1:0] qp_log[$];
  int            full_blocks = 0;
  int            part_cnt = 0;
  logic [CW-1:0] part [16];
  logic [QW-1:0] part_qp;
  bit            part_field;
  bit            last_acc;

  int scan_frame [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  int scan_field [16] = '{0, 4, 1, 8, 12, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  int frame_ref  [16] = '{0, 1, 5, 6, 2, 4, 7, 12, 3, 8, 11, 13, 9, 10, 14, 15};
  int field_ref  [16] = '{0, 2, 8, 12, 1, 5, 9, 13, 3, 6, 10, 14, 4, 7, 11, 15};
  int qps        [3]  = '{10, 20, 30};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    full_blocks = 0;
    part_cnt = 0;
  endtask

  // One clock: check outputs against the model, drive new inputs, advance the model.
  task automatic step(input bit v, input logic [CW-1:0] c, input logic [QW-1:0] q,
                      input bit r, input bit f, input bit fm);
    bit ev, er;
    exp_t e;
    logic [CW-1:0] ras [16];
    @(negedge clk);
    ev = (full_blocks > 0);
    er = (full_blocks < 2);
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, er);
    if (ev) begin
      e = exp_q[0];
      chk("out_coef", out_coef, e.coef);
      chk("out_pos", out_pos, e.pos);
      chk("out_qp", out_qp, e.qp);
      chk("out_last", out_last, (e.pos == 4'd15));
    end
    in_valid  = v;
    in_coef   = c;
    in_qp     = q;
    out_ready = r;
    flush     = f;
`ifdef ZIGZAG_FIELD_SCAN_EN
    field_mode = fm;
`endif
    last_acc = 1'b0;
    if (f) begin
      model_reset();
    end else begin
      if (ev && r) begin
        e = exp_q.pop_front();
        out_log.push_back(e.coef);
        qp_log.push_back(e.qp);
        $display("out pos=%0d coef=%0h qp=%0d", e.pos, e.coef, e.qp);
        if (e.pos == 4'd15) full_blocks--;
      end
      if (v && er) begin
        last_acc = 1'b1;
        if (part_cnt == 0) begin
          part_qp    = q;
          part_field = fm && FIELD_EN;
        end
        part[part_cnt] = c;
        part_cnt++;
        if (part_cnt == 16) begin
          for (int k = 0; k < 16; k++)
            ras[part_field ? scan_field[k] : scan_frame[k]] = part[k];
          for (int p = 0; p < 16; p++)
            exp_q.push_back('{coef: ras[p], pos: 4'(p), qp: part_qp});
          full_blocks++;
          part_cnt = 0;
        end
      end
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      step(0, '0, '0, 1, 0, 0);
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_coef"}, out_coef, 0);
    chk({tag, "_out_pos"}, out_pos, 0);
    chk({tag, "_out_qp"}, out_qp, 0);
    chk({tag, "_out_last"}, out_last, 0);
  endtask

  initial begin
    int idx;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Single frame-scan block, in_coef = scan index
    out_log.delete();
    for (int k = 0; k < 16; k++) step(1, 16'(k), 6'd7, 1, 0, 0);
    drain(40);
    chk("t1_count", out_log.size(), 16);
    for (int i = 0; i < 16 && i < out_log.size(); i++) chk("t1_order", out_log[i], frame_ref[i]);

`ifdef ZIGZAG_FIELD_SCAN_EN
    // Single field-scan block
    out_log.delete();
    for (int k = 0; k < 16; k++) step(1, 16'(k), 6'd3, 1, 0, 1);
    drain(40);
    chk("fld_count", out_log.size(), 16);
    for (int i = 0; i < 16 && i < out_log.size(); i++) chk("fld_order", out_log[i], field_ref[i]);
`endif

    // Three blocks against a stalled consumer, then release
    qp_log.delete();
    idx = 0;
    for (int i = 0; i < 48; i++) begin
      step(1, 16'($urandom), 6'(qps[idx / 16]), 0, 0, 0);
      if (last_acc) idx++;
    end
    for (int i = 0; i < 200 && (idx < 48 || exp_q.size() > 0); i++) begin
      step(idx < 48, 16'($urandom), 6'(qps[(idx < 48) ? idx / 16 : 2]), 1, 0, 0);
      if (last_acc) idx++;
    end
    chk("t2_count", qp_log.size(), 48);
    for (int i = 0; i < 48 && i < qp_log.size(); i++) chk("t2_qp", qp_log[i], qps[i / 16]);

    // Random input with out_ready toggling every cycle
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1), 16'($urandom), 6'($urandom), i[0], 0, $urandom_range(0, 1));
    drain(80);

    // Flush with block 1 partly read and block 2 partly written
    for (int k = 0; k < 16; k++) step(1, 16'($urandom), 6'd12, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(1, 16'($urandom), 6'd13, 1, 0, 0);
    step(1, 16'($urandom), 6'd13, 1, 1, 0);
    step(0, '0, '0, 1, 0, 0);
    for (int k = 0; k < 16; k++) step(1, 16'($urandom), 6'd21, 1, 0, $urandom_range(0, 1));
    drain(40);

    // Asynchronous reset mid-stream, applied and released off the clock edges
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 1), 16'($urandom), 6'($urandom), $urandom_range(0, 1), 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 16; k++) step(1, 16'($urandom), 6'd33, 1, 0, $urandom_range(0, 1));
    drain(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
